// File: rtl/booth_pkg.sv
// Shared types and helpers for the shared Booth multiplier arbiter.
// Holds the controller state encoding, default sizes and the round-robin pick.
package booth_pkg;

    localparam int unsigned N_DEF    = 4;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned MAX_REQ  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set request at or after ptr, wrapping within nreq requesters.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [2:0]         ptr,
                                      input int unsigned        nreq);
        pick_t       res;
        int unsigned cand;
        logic [2:0]  cand3;
        res = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            cand  = (32'(ptr) + i) % nreq;
            cand3 = 3'(cand);
            if ((i < nreq) && !res.found && req[cand3]) begin
                res.found = 1'b1;
                res.idx   = cand3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/booth_mul_core.sv
// Sequential radix-2 Booth multiplier: one cycle per plain shift, two per add/sub+shift.
// No reset; load clears done and restarts the job.
module booth_mul_core #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           load,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] rez,
    output logic           done
);

    localparam int unsigned CW = $clog2(N + 1);

    // One guard bit in the accumulator keeps -min * -min from overflowing.
    logic [N:0]    r_acc;
    logic [N:0]    r_m;
    logic [N-1:0]  r_q;
    logic          r_qm1;
    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          r_done;
    logic [1:0]    w_pair;

    assign w_pair = {r_q[0], r_qm1};

    always_ff @(posedge clk) begin
        if (load) begin
            r_acc   <= '0;
            r_m     <= {a[N-1], a};
            r_q     <= b;
            r_qm1   <= 1'b0;
            r_cnt   <= CW'(N);
            r_phase <= 1'b0;
            r_done  <= 1'b0;
        end else if (!r_done) begin
            if (!r_phase && (w_pair == 2'b01)) begin
                r_acc   <= r_acc + r_m;
                r_phase <= 1'b1;
            end else if (!r_phase && (w_pair == 2'b10)) begin
                r_acc   <= r_acc - r_m;
                r_phase <= 1'b1;
            end else begin
                {r_acc, r_q, r_qm1} <= {r_acc[N], r_acc, r_q};
                r_phase <= 1'b0;
                r_cnt   <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign rez  = {r_acc[N-1:0], r_q};
    assign done = r_done;

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one sequential Booth multiplier among NREQ requesters.
// Latches the winner's operands at grant and returns the product with a one-hot valid pulse.
module booth_mul_arbiter
    import booth_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] a_bus,
    input  logic [NREQ*N-1:0] b_bus,
    output logic [NREQ-1:0]   gnt,
    output logic [2*N-1:0]    rez,
    output logic [NREQ-1:0]   rez_valid,
    output logic              busy
);

    state_e            r_state;
    state_e            w_next;
    logic [IDXW-1:0]   r_ptr;
    logic [IDXW-1:0]   r_idx;
    logic [N-1:0]      r_a;
    logic [N-1:0]      r_b;
    logic [NREQ-1:0]   r_gnt;
    logic [2*N-1:0]    r_rez;
    logic [NREQ-1:0]   r_rez_valid;

    logic [MAX_REQ-1:0] w_req8;
    pick_t              w_pick;
    logic [IDXW-1:0]    w_win;
    logic [IDXW-1:0]    w_ptr_next;
    logic               w_load;
    logic               w_busy;
    logic [2*N-1:0]     w_core_rez;
    logic               w_core_done;

    always_comb begin
        w_req8             = '0;
        w_req8[NREQ-1:0]   = req;
    end

    assign w_pick     = rr_pick(w_req8, 3'(r_ptr), NREQ);
    assign w_win      = IDXW'(w_pick.idx);
    assign w_ptr_next = (r_idx == IDXW'(NREQ - 1)) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    // Core done is stale until the load edge clears it, so only RUN looks at it.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle:  if (w_pick.found) w_next = StLoad;
            StLoad:  w_next = StRun;
            StRun:   if (w_core_done) w_next = StIdle;
            default: w_next = StIdle;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_busy = 1'b0;
        unique case (r_state)
            StIdle:  w_busy = 1'b0;
            StLoad:  begin
                w_load = 1'b1;
                w_busy = 1'b1;
            end
            StRun:   w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_gnt       <= '0;
            r_rez       <= '0;
            r_rez_valid <= '0;
        end else begin
            r_rez_valid <= '0;
            if ((r_state == StIdle) && w_pick.found) begin
                r_idx <= w_win;
                r_a   <= a_bus[N*int'(w_win) +: N];
                r_b   <= b_bus[N*int'(w_win) +: N];
                r_gnt <= NREQ'(1) << w_win;
            end
            if ((r_state == StRun) && w_core_done) begin
                r_rez       <= w_core_rez;
                r_rez_valid <= NREQ'(1) << r_idx;
                r_gnt       <= '0;
                r_ptr       <= w_ptr_next;
            end
        end
    end

    booth_mul_core #(
        .N (N)
    ) u_core (
        .clk  (clk),
        .load (w_load),
        .a    (r_a),
        .b    (r_b),
        .rez  (w_core_rez),
        .done (w_core_done)
    );

    assign gnt       = r_gnt;
    assign rez       = r_rez;
    assign rez_valid = r_rez_valid;
    assign busy      = w_busy;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a per-cycle round-robin/product model.
module tb_booth_mul_arbiter;

    localparam int N    = 4;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*N-1:0] a_bus = '0;
    logic [NREQ*N-1:0] b_bus = '0;
    logic [NREQ-1:0]   gnt;
    logic [2*N-1:0]    rez;
    logic [NREQ-1:0]   rez_valid;
    logic              busy;

    int total = 0;
    int bad   = 0;

    booth_mul_arbiter #(
        .N    (N),
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .gnt       (gnt),
        .rez       (rez),
        .rez_valid (rez_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [NREQ-1:0] r, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    // Model: arbitration happens at edges where no job is in flight.
    int                m_ptr  = 0;
    bit                m_open = 1'b0;
    int                m_idx  = 0;
    logic [2*N-1:0]    m_prod = '0;
    logic [2*N-1:0]    m_rez  = '0;
    int                lat    = 0;
    logic              p_rst  = 1'b1;
    logic [NREQ-1:0]   p_req  = '0;
    logic [NREQ*N-1:0] p_a    = '0;
    logic [NREQ*N-1:0] p_b    = '0;

    always @(negedge clk) begin : cmp
        bit         was_open;
        int         win;
        int         sa;
        int         sb;
        logic [N-1:0] ta;
        logic [N-1:0] tb;
        if (p_rst) begin
            check("rst_gnt", 32'(gnt), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_rez", 32'(rez), 0);
            check("rst_valid", 32'(rez_valid), 0);
            m_ptr  = 0;
            m_open = 1'b0;
            m_rez  = '0;
        end else begin
            was_open = m_open;
            if (m_open) lat++;
            if (rez_valid != '0) begin
                check("valid_expected", 32'(m_open), 1);
                check("valid_onehot", 32'(rez_valid), 32'(1) << m_idx);
                check("valid_rez", 32'(rez), 32'(m_prod));
                check("latency_range", 32'((lat >= N + 2) && (lat <= 2 * N + 2)), 1);
                check("gnt_cleared", 32'(gnt), 0);
                m_rez  = m_prod;
                m_open = 1'b0;
                m_ptr  = (m_idx + 1) % NREQ;
            end else begin
                check("rez_hold", 32'(rez), 32'(m_rez));
                if (!was_open) begin
                    win = rr(p_req, m_ptr);
                    if (win >= 0) begin
                        ta     = p_a[win*N +: N];
                        tb     = p_b[win*N +: N];
                        sa     = $signed(ta);
                        sb     = $signed(tb);
                        m_prod = (2*N)'(sa * sb);
                        m_idx  = win;
                        m_open = 1'b1;
                        lat    = 0;
                        check("grant_onehot", 32'(gnt), 32'(1) << win);
                    end else begin
                        check("idle_gnt", 32'(gnt), 0);
                    end
                end else begin
                    check("gnt_held", 32'(gnt), 32'(1) << m_idx);
                    if (lat > 2 * N + 2) begin
                        check("job_timeout", 32'(lat), 32'(2 * N + 2));
                        m_open = 1'b0;
                    end
                end
            end
            check("busy_track", 32'(busy), 32'(m_open));
        end
        p_rst = rst;
        p_req = req;
        p_a   = a_bus;
        p_b   = b_bus;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        a_bus[i*N +: N] = a;
        b_bus[i*N +: N] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int i);
        bit ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            tick();
            if (rez_valid[i]) ok = 1'b1;
        end
        if (!ok) check("valid_timeout", 0, 1);
    endtask

    task automatic wait_gnt(input int i);
        bit ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            tick();
            if (gnt[i]) ok = 1'b1;
        end
        if (!ok) check("gnt_timeout", 0, 1);
    endtask

    task automatic run_one(input string name, input int i, input logic [N-1:0] a,
                           input logic [N-1:0] b, input logic [2*N-1:0] exp);
        set_ops(i, a, b);
        req[i] = 1'b1;
        wait_valid(i);
        check(name, 32'(rez), 32'(exp));
        req[i] = 1'b0;
        check({name, "_busy_after"}, 32'(busy), 0);
        tick();
        check({name, "_single_pulse"}, 32'(rez_valid), 0);
    endtask

    int             ord[$];
    logic [2*N-1:0] res[$];
    int             exp_ord[5] = '{0, 1, 2, 3, 0};
    logic [2*N-1:0] exp_res[5] = '{8'h01, 8'h06, 8'h40, 8'hF9, 8'h01};

    initial begin
        do_reset();
        check("reset_gnt", 32'(gnt), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_rez", 32'(rez), 0);

        run_one("single_3x-4", 0, 4'h3, 4'hC, 8'hF4);

        // Contention, all four requesting continuously from ptr=0.
        do_reset();
        set_ops(0, 4'h1, 4'h1);
        set_ops(1, 4'h2, 4'h3);
        set_ops(2, 4'h8, 4'h8);
        set_ops(3, 4'h7, 4'hF);
        req = 4'hF;
        for (int k = 0; k < 80 && ord.size() < 5; k++) begin
            tick();
            if (rez_valid != '0) begin
                for (int j = 0; j < NREQ; j++) if (rez_valid[j]) ord.push_back(j);
                res.push_back(rez);
            end
        end
        req = '0;
        check("contention_count", 32'(ord.size()), 5);
        for (int j = 0; j < 5 && j < ord.size(); j++) begin
            check($sformatf("contention_order%0d", j), 32'(ord[j]), 32'(exp_ord[j]));
            check($sformatf("contention_rez%0d", j), 32'(res[j]), 32'(exp_res[j]));
        end
        tick();

        do_reset();
        run_one("corner_-8x-8", 2, 4'h8, 4'h8, 8'h40);
        run_one("corner_-8x7", 1, 4'h8, 4'h7, 8'hC8);
        run_one("corner_0x5", 3, 4'h0, 4'h5, 8'h00);
        run_one("alt_A_x_5", 0, 4'hA, 4'h5, 8'hE2);
        run_one("alt_5_x_A", 1, 4'h5, 4'hA, 8'hE2);

        // Operands change mid-job; product must use the granted values.
        set_ops(2, 4'h5, 4'h3);
        req[2] = 1'b1;
        wait_gnt(2);
        tick();
        tick();
        tick();
        a_bus = {NREQ{4'h7}};
        b_bus = {NREQ{4'hF}};
        wait_valid(2);
        check("opchange_rez", 32'(rez), 32'h0F);
        req = '0;
        tick();

        // Late arrival of requester 1 while requester 0 is running.
        set_ops(0, 4'h3, 4'h3);
        set_ops(1, 4'hE, 4'h6);
        req = 4'b0001;
        wait_gnt(0);
        tick();
        tick();
        tick();
        req[1] = 1'b1;
        wait_valid(0);
        check("late_rez0", 32'(rez), 32'h09);
        req[0] = 1'b0;
        wait_gnt(1);
        check("late_next_gnt", 32'(gnt), 32'b0010);
        wait_valid(1);
        check("late_rez1", 32'(rez), 32'hF4);
        req = '0;
        tick();

        // Reset while requester 2 runs; ptr is 2 beforehand, so 0 winning proves ptr=0.
        do_reset();
        run_one("pre_abort", 1, 4'h1, 4'h2, 8'h02);
        set_ops(0, 4'h2, 4'h2);
        set_ops(2, 4'h9, 4'h3);
        req = 4'b0100;
        wait_gnt(2);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        req = 4'b0101;
        tick();
        check("abort_gnt", 32'(gnt), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_rez", 32'(rez), 0);
        check("abort_valid", 32'(rez_valid), 0);
        rst = 1'b0;
        wait_valid(0);
        check("abort_first_rez", 32'(rez), 32'h04);
        req[0] = 1'b0;
        wait_valid(2);
        check("abort_reserve_rez", 32'(rez), 32'hEB);
        req = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
